// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB-Lite definitions for the SRAM responder slice:
//   transfer-type and size codes, the data-phase state encoding, and
//   small decode helpers used by the responder datapath.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Data-phase state of the transfer accepted in the previous cycle.
    typedef enum logic [2:0] {
        DPH_NONE,
        DPH_READ,
        DPH_READ_STALL,
        DPH_WRITE,
        DPH_ERR1,
        DPH_ERR2
    } dph_state_t;

    // Byte lanes touched by a transfer of the given size at the given lane.
    function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = 4'b0011 << lane;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Oversized or misaligned transfers are answered with ERROR.
    function automatic logic xfer_error(input logic [2:0] size,
                                        input logic [1:0] lane);
        return (size > HSIZE_WORD)
            || (size == HSIZE_HALF && lane[0])
            || (size == HSIZE_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// ahb_sram_responder_if
//   AHB-Lite bus bundle between the single master and the SRAM responder.
//   Master drives: hsel, haddr, htrans, hwrite, hsize, hprot, hexcl,
//                  hready (bus-level), hwdata.
//   Slave drives:  hready_resp, hresp, hexokay, hrdata.
interface ahb_sram_responder_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              ahbls_hsel;
    logic [W_ADDR-1:0] ahbls_haddr;
    logic [1:0]        ahbls_htrans;
    logic              ahbls_hwrite;
    logic [2:0]        ahbls_hsize;
    logic [3:0]        ahbls_hprot;
    logic              ahbls_hexcl;
    logic              ahbls_hready;
    logic [W_DATA-1:0] ahbls_hwdata;
    logic              ahbls_hready_resp;
    logic              ahbls_hresp;
    logic              ahbls_hexokay;
    logic [W_DATA-1:0] ahbls_hrdata;

    modport slave (
        input  ahbls_hsel, ahbls_haddr, ahbls_htrans, ahbls_hwrite,
               ahbls_hsize, ahbls_hprot, ahbls_hexcl, ahbls_hready,
               ahbls_hwdata,
        output ahbls_hready_resp, ahbls_hresp, ahbls_hexokay, ahbls_hrdata
    );

    modport master (
        output ahbls_hsel, ahbls_haddr, ahbls_htrans, ahbls_hwrite,
               ahbls_hsize, ahbls_hprot, ahbls_hexcl, ahbls_hready,
               ahbls_hwdata,
        input  ahbls_hready_resp, ahbls_hresp, ahbls_hexokay, ahbls_hrdata
    );
endinterface

// File: rtl/ahb_sram_excl_monitor.sv
// ahb_sram_excl_monitor
//   Single-entry reservation for LR/SC style exclusive accesses.
//   Built only when AHB_SRAM_EXCL_MONITOR_EN is defined.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (clears reservation)
//     set_i        exclusive read accepted: reserve set_addr_i
//     clear_i      write data phase that must drop the reservation
//     check_i      qualifies match_o (write data phase in progress)
//     set_addr_i   word address being reserved
//     chk_addr_i   word address of the write in its data phase
//     match_o      reservation valid and covering chk_addr_i
`ifdef AHB_SRAM_EXCL_MONITOR_EN
module ahb_sram_excl_monitor #(
    parameter int W_SRAM_ADDR = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_i,
    input  logic                   clear_i,
    input  logic                   check_i,
    input  logic [W_SRAM_ADDR-1:0] set_addr_i,
    input  logic [W_SRAM_ADDR-1:0] chk_addr_i,
    output logic                   match_o
);
    logic                   valid_q;
    logic [W_SRAM_ADDR-1:0] addr_q;

    // A new reservation takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            addr_q  <= set_addr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign match_o = check_i && valid_q && (addr_q == chk_addr_i);
endmodule
`endif

// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder
//   AHB-Lite slave in front of a single-port synchronous SRAM.
//   Reads: zero wait states (one wait when directly behind a write).
//   Writes: commit in the data phase. Oversize/misaligned transfers get
//   the two-cycle ERROR response. Exclusive monitor is present only when
//   AHB_SRAM_EXCL_MONITOR_EN is defined; otherwise hexokay is 0 and
//   exclusive writes are dropped.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     bus          AHB-Lite slave modport (ahbls_* signals)
//     sram_addr    SRAM word address
//     sram_ce      SRAM enable
//     sram_we      SRAM write
//     sram_wbe     SRAM byte enables
//     sram_wdata   SRAM write data
//     sram_rdata   SRAM read data, one cycle after a read enable
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 4096,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    ahb_sram_responder_if.slave    bus,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [3:0]             sram_wbe,
    output logic [W_DATA-1:0]      sram_wdata,
    input  logic [W_DATA-1:0]      sram_rdata
);

    dph_state_t state_q, state_d;

    logic [W_SRAM_ADDR-1:0] waddr_q;
    logic [1:0]             lane_q;
    logic [2:0]             size_q;
    logic                   excl_q;

    logic                   aph_valid;
    logic                   aph_err;
    logic                   aph_read;
    logic [W_SRAM_ADDR-1:0] aph_widx;
    logic                   excl_pass;
    logic                   excl_rd_okay;
    logic                   wr_commit;

    assign aph_valid = bus.ahbls_hsel && bus.ahbls_htrans[1] && bus.ahbls_hready;
    assign aph_err   = xfer_error(bus.ahbls_hsize, bus.ahbls_haddr[1:0]);
    assign aph_read  = aph_valid && !aph_err && !bus.ahbls_hwrite;
    assign aph_widx  = bus.ahbls_haddr[W_SRAM_ADDR+1:2];

    // Upper address bits alias onto the SRAM; hprot has no effect here.
    logic unused_ok;
    assign unused_ok = ^{bus.ahbls_hprot, bus.ahbls_htrans[0],
                         bus.ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            lane_q  <= '0;
            size_q  <= HSIZE_BYTE;
            excl_q  <= 1'b0;
        end else if (aph_valid) begin
            waddr_q <= aph_widx;
            lane_q  <= bus.ahbls_haddr[1:0];
            size_q  <= bus.ahbls_hsize;
            excl_q  <= bus.ahbls_hexcl;
        end
    end

`ifdef AHB_SRAM_EXCL_MONITOR_EN
    logic mon_check;
    logic mon_clear;

    assign mon_check = (state_q == DPH_WRITE);
    // Exclusive writes always drop the reservation; plain writes only when
    // they hit the reserved word.
    assign mon_clear = mon_check && (excl_q || excl_pass);

    ahb_sram_excl_monitor #(
        .W_SRAM_ADDR (W_SRAM_ADDR)
    ) u_excl_monitor (
        .clk        (clk),
        .rst        (rst),
        .set_i      (aph_read && bus.ahbls_hexcl),
        .clear_i    (mon_clear),
        .check_i    (mon_check),
        .set_addr_i (aph_widx),
        .chk_addr_i (waddr_q),
        .match_o    (excl_pass)
    );

    assign excl_rd_okay = excl_q;
`else
    assign excl_pass    = 1'b0;
    assign excl_rd_okay = 1'b0;
`endif

    // A failed exclusive write completes with OKAY but never reaches SRAM.
    assign wr_commit = (state_q == DPH_WRITE) && (!excl_q || excl_pass) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DPH_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DPH_READ_STALL: state_d = DPH_READ;
            DPH_ERR1:       state_d = DPH_ERR2;
            default: begin
                if (!aph_valid) begin
                    state_d = DPH_NONE;
                end else if (aph_err) begin
                    state_d = DPH_ERR1;
                end else if (bus.ahbls_hwrite) begin
                    state_d = DPH_WRITE;
                end else if (state_q == DPH_WRITE) begin
                    state_d = DPH_READ_STALL;
                end else begin
                    state_d = DPH_READ;
                end
            end
        endcase
    end

    always_comb begin
        bus.ahbls_hready_resp = !(state_q == DPH_READ_STALL || state_q == DPH_ERR1);
        bus.ahbls_hresp       = (state_q == DPH_ERR1) || (state_q == DPH_ERR2);
        bus.ahbls_hrdata      = (state_q == DPH_READ) ? sram_rdata : '0;
        bus.ahbls_hexokay     = ((state_q == DPH_READ) && excl_rd_okay)
                             || ((state_q == DPH_WRITE) && excl_q && excl_pass);

        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = aph_widx;
        sram_wbe   = byte_enables(size_q, lane_q);
        sram_wdata = bus.ahbls_hwdata;

        // The single port serves, in priority order: the write commit, a
        // read deferred behind that commit, then a fresh address-phase read.
        if (!rst) begin
            if (state_q == DPH_WRITE) begin
                sram_ce   = wr_commit;
                sram_we   = wr_commit;
                sram_addr = waddr_q;
            end else if (state_q == DPH_READ_STALL) begin
                sram_ce   = 1'b1;
                sram_addr = waddr_q;
            end else if (aph_read) begin
                sram_ce   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
module tb_ahb_sram_responder;

    localparam int DEPTH = 4096;
    localparam int WSA   = $clog2(DEPTH);

`ifdef AHB_SRAM_EXCL_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tb_clear;

    logic [WSA-1:0] sram_addr;
    logic           sram_ce;
    logic           sram_we;
    logic [3:0]     sram_wbe;
    logic [31:0]    sram_wdata;
    logic [31:0]    sram_rdata;

    ahb_sram_responder_if #(.W_ADDR(32), .W_DATA(32)) bus ();

    assign bus.ahbls_hready = bus.ahbls_hready_resp;

    ahb_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .sram_addr  (sram_addr),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wbe   (sram_wbe),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM device model
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 32'h0;
            sram_rdata <= 32'h0;
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wbe[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference state
    logic [31:0] ref_mem [DEPTH];
    bit          r_valid;
    int unsigned r_widx;

    // Expectation for the transfer currently in its data phase
    bit          p_valid, p_wr, p_err, p_stall, p_okay, p_perf;
    logic [31:0] p_rdata, p_wdata;
    logic [3:0]  p_mask;
    int unsigned p_widx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [2:0] size, input logic [31:0] addr);
        int unsigned bytes;
        if (size > 3'd2) return 1'b1;
        bytes = 32'd1 << size;
        return (addr % bytes) != 0;
    endfunction

    // One bus cycle group: present an address phase (or idle) while the
    // previous transfer runs its data phase, then step past acceptance.
    task automatic step(input bit act, input bit wr, input bit excl,
                        input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int          ncyc;
        bit          last, nerr, after_wr;
        int unsigned widx, m;
        nerr = is_err(size, addr);
        bus.ahbls_hsel   = act;
        bus.ahbls_htrans = act ? 2'b10 : 2'b00;
        bus.ahbls_haddr  = addr;
        bus.ahbls_hwrite = wr;
        bus.ahbls_hsize  = size;
        bus.ahbls_hexcl  = excl;
        bus.ahbls_hprot  = 4'($urandom);
        ncyc = (p_valid && (p_err || p_stall)) ? 2 : 1;
        for (int c = 0; c < ncyc; c++) begin
            last = (c == ncyc - 1);
            bus.ahbls_hwdata = (p_valid && p_wr) ? p_wdata : $urandom;
            #1;
            if (!p_valid) begin
                chk("idle_hready", 32'(bus.ahbls_hready_resp), 32'd1);
                chk("idle_hresp", 32'(bus.ahbls_hresp), 32'd0);
                chk("idle_hexokay", 32'(bus.ahbls_hexokay), 32'd0);
                chk("idle_hrdata", bus.ahbls_hrdata, 32'd0);
            end else if (p_err) begin
                chk("err_hready", 32'(bus.ahbls_hready_resp), 32'(last));
                chk("err_hresp", 32'(bus.ahbls_hresp), 32'd1);
                chk("err_hexokay", 32'(bus.ahbls_hexokay), 32'd0);
                if (!last || !act || wr || nerr)
                    chk("err_sram_ce", 32'(sram_ce), 32'd0);
            end else if (p_stall && !last) begin
                chk("stall_hready", 32'(bus.ahbls_hready_resp), 32'd0);
                chk("stall_hresp", 32'(bus.ahbls_hresp), 32'd0);
                chk("stall_hrdata", bus.ahbls_hrdata, 32'd0);
                chk("stall_sram_ce", 32'(sram_ce), 32'd1);
                chk("stall_sram_we", 32'(sram_we), 32'd0);
                chk("stall_sram_addr", 32'(sram_addr), p_widx);
            end else if (!p_wr) begin
                chk("rd_hready", 32'(bus.ahbls_hready_resp), 32'd1);
                chk("rd_hresp", 32'(bus.ahbls_hresp), 32'd0);
                chk("rd_hrdata", bus.ahbls_hrdata, p_rdata);
                chk("rd_hexokay", 32'(bus.ahbls_hexokay), 32'(p_okay));
            end else begin
                chk("wr_hready", 32'(bus.ahbls_hready_resp), 32'd1);
                chk("wr_hresp", 32'(bus.ahbls_hresp), 32'd0);
                chk("wr_hexokay", 32'(bus.ahbls_hexokay), 32'(p_okay));
                chk("wr_hrdata", bus.ahbls_hrdata, 32'd0);
                chk("wr_sram_we", 32'(sram_we), 32'(p_perf));
                if (p_perf) begin
                    chk("wr_sram_wbe", 32'(sram_wbe), 32'(p_mask));
                    chk("wr_sram_addr", 32'(sram_addr), p_widx);
                    chk("wr_sram_wdata", sram_wdata, p_wdata);
                end
            end
            if (!last) begin
                @(posedge clk);
                #1;
            end
        end
        // Reference model: the new transfer is accepted at the coming edge.
        after_wr = p_valid && p_wr && !p_err;
        if (act) begin
            widx    = (addr >> 2) % DEPTH;
            p_valid = 1'b1;
            p_wr    = wr;
            p_err   = nerr;
            p_stall = !nerr && !wr && after_wr;
            p_okay  = 1'b0;
            p_perf  = 1'b0;
            p_rdata = 32'h0;
            p_widx  = widx;
            p_wdata = wdata;
            p_mask  = 4'h0;
            if (!nerr) begin
                if (!wr) begin
                    p_rdata = ref_mem[widx];
                    if (MON && excl) begin
                        r_valid = 1'b1;
                        r_widx  = widx;
                        p_okay  = 1'b1;
                    end
                end else begin
                    p_perf = !excl || (MON && r_valid && r_widx == widx);
                    p_okay = excl && p_perf;
                    if (excl || r_widx == widx) r_valid = 1'b0;
                    m = ((32'd1 << (32'd1 << size)) - 1) << addr[1:0];
                    p_mask = m[3:0];
                    if (p_perf)
                        for (int b = 0; b < 4; b++)
                            if (p_mask[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            p_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] s, input bit x);
        step(1'b1, 1'b1, x, s, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s, input bit x);
        step(1'b1, 1'b0, x, s, a, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d, saved;
        logic [2:0]  s;
        int unsigned k;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        r_valid = 1'b0;
        r_widx  = 0;
        p_valid = 1'b0;
        p_wr = 1'b0; p_err = 1'b0; p_stall = 1'b0; p_okay = 1'b0; p_perf = 1'b0;
        p_rdata = 32'h0; p_wdata = 32'h0; p_mask = 4'h0; p_widx = 0;

        rst = 1'b1;
        tb_clear = 1'b1;
        bus.ahbls_hsel = 1'b0; bus.ahbls_htrans = 2'b00; bus.ahbls_haddr = 32'h0;
        bus.ahbls_hwrite = 1'b0; bus.ahbls_hsize = 3'd2; bus.ahbls_hprot = 4'h0;
        bus.ahbls_hexcl = 1'b0; bus.ahbls_hwdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tb_clear = 1'b0;
        chk("rst_hready", 32'(bus.ahbls_hready_resp), 32'd1);
        chk("rst_hresp", 32'(bus.ahbls_hresp), 32'd0);
        chk("rst_hexokay", 32'(bus.ahbls_hexokay), 32'd0);
        chk("rst_hrdata", bus.ahbls_hrdata, 32'd0);
        chk("rst_sram_ce", 32'(sram_ce), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word write then read
        wr(32'h20, 32'hDEADBEEF, 3'd2, 1'b0);
        idle();
        rd(32'h20, 3'd2, 1'b0);
        idle();

        // Byte write with a back-to-back read behind it
        wr(32'h23, 32'hAA000000, 3'd0, 1'b0);
        rd(32'h20, 3'd2, 1'b0);
        idle();

        // Misaligned halfword
        rd(32'h21, 3'd1, 1'b0);
        idle();
        idle();

        // Exclusive pair, then a stale SC
        rd(32'h40, 3'd2, 1'b1);
        wr(32'h40, 32'd5, 3'd2, 1'b1);
        wr(32'h40, 32'd6, 3'd2, 1'b1);
        idle();
        rd(32'h40, 3'd2, 1'b0);
        idle();

        // Plain write breaks the reservation
        rd(32'h40, 3'd2, 1'b1);
        wr(32'h40, 32'd7, 3'd2, 1'b0);
        wr(32'h40, 32'd8, 3'd2, 1'b1);
        idle();
        rd(32'h40, 3'd2, 1'b0);
        idle();

        // Reservation set in the same cycle as a clearing write: set wins
        rd(32'h44, 3'd2, 1'b1);
        wr(32'h44, 32'h11, 3'd2, 1'b0);
        rd(32'h44, 3'd2, 1'b1);
        wr(32'h44, 32'h22, 3'd2, 1'b1);
        idle();
        rd(32'h44, 3'd2, 1'b0);
        idle();

        // Word index wraps modulo DEPTH
        wr(32'h20 + 32'(DEPTH * 4), 32'h0BADF00D, 3'd2, 1'b0);
        rd(32'h20, 3'd2, 1'b0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)      s = 3'd0;
            else if (k <= 5) s = 3'd1;
            else if (k <= 8) s = 3'd2;
            else             s = 3'($urandom_range(3, 7));
            a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && s <= 3'd2) a = a & ~((32'd1 << s) - 1);
            d = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) idle();
            else step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, s, a, d);
        end
        idle();
        for (int i = 0; i < 32; i++) rd(32'(i * 4), 3'd2, 1'b0);
        idle();

        // Reset during a write data phase
        rd(32'h40, 3'd2, 1'b1);
        idle();
        saved = ref_mem[32];
        wr(32'h80, 32'h12345678, 3'd2, 1'b0);
        bus.ahbls_hsel = 1'b0;
        bus.ahbls_htrans = 2'b00;
        bus.ahbls_hwdata = p_wdata;
        rst = 1'b1;
        #1;
        chk("rstw_sram_we", 32'(sram_we), 32'd0);
        chk("rstw_sram_ce", 32'(sram_ce), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstw_hready", 32'(bus.ahbls_hready_resp), 32'd1);
        chk("rstw_hresp", 32'(bus.ahbls_hresp), 32'd0);
        chk("rstw_sram_we", 32'(sram_we), 32'd0);
        ref_mem[32] = saved;
        r_valid = 1'b0;
        p_valid = 1'b0;
        @(posedge clk);
        #1;
        wr(32'h40, 32'h99, 3'd2, 1'b1);
        idle();
        rd(32'h40, 3'd2, 1'b0);
        rd(32'h80, 3'd2, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
